// File: rtl/frame_rx_pkg.sv
// Shared types and link constants for the frame_rx byte-stream receiver.
package frame_rx_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    PRE,
    DATA,
    DROP
  } state_e;

  typedef enum logic [1:0] {
    OK       = 2'd0,
    ERR_CSUM = 2'd1,
    ERR_LEN  = 2'd2,
    ERR_PRE  = 2'd3
  } status_e;

  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;
  localparam int unsigned MAX_PRE  = 7;

endpackage

// File: rtl/frame_rx_hold.sv
// Two-entry hold pipeline: delays body bytes by two so the checksum byte is never forwarded.
module frame_rx_hold (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       flush_i,
  input  logic       clear_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       last_o
);

  logic [7:0] h0_q, h1_q;
  logic       v0_q, v1_q;
  logic [7:0] data_q;
  logic       valid_q, last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0_q    <= '0;
      h1_q    <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      if (clear_i) begin
        v0_q <= 1'b0;
        v1_q <= 1'b0;
      end else if (flush_i) begin
        // Older entry is the final payload byte; newer entry is the checksum.
        if (v1_q) begin
          data_q  <= h1_q;
          valid_q <= 1'b1;
          last_q  <= 1'b1;
        end
        v0_q <= 1'b0;
        v1_q <= 1'b0;
      end else if (push_i) begin
        if (v1_q) begin
          data_q  <= h1_q;
          valid_q <= 1'b1;
        end
        h1_q <= h0_q;
        v1_q <= v0_q;
        h0_q <= data_i;
        v0_q <= 1'b1;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;

endmodule

// File: rtl/frame_rx.sv
// Frame receiver: preamble/SFD strip, additive checksum check, payload stream and frame counters.
module frame_rx
  import frame_rx_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1500,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rxd,
  input  logic             rx_dv,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic             frame_done,
  output logic [1:0]       frame_status,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned   NW    = $clog2(MAX_LEN + 2);
  localparam logic [NW-1:0] N_OVF = NW'(MAX_LEN + 1);

  state_e        state_q, state_d;
  logic [2:0]    pre_q, pre_d;
  logic [7:0]    sum_q, sum_d;
  logic [NW-1:0] n_q, n_d;
  logic          report;
  status_e       rep_status;
  logic          push, flush, clear;
  logic          done_q;
  status_e       status_q;
  logic [CNT_W-1:0] ok_q, err_q;

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    sum_d      = sum_q;
    n_d        = n_q;
    report     = 1'b0;
    rep_status = OK;
    push       = 1'b0;
    flush      = 1'b0;
    clear      = 1'b0;
    unique case (state_q)
      WAIT_IDLE: if (!rx_dv) state_d = IDLE;
      IDLE: if (rx_dv) begin
        if (rxd == PRE_BYTE) begin
          state_d = PRE;
          pre_d   = 3'd1;
        end else begin
          report     = 1'b1;
          rep_status = ERR_PRE;
          state_d    = DROP;
        end
      end
      PRE: begin
        if (!rx_dv) begin
          report     = 1'b1;
          rep_status = ERR_PRE;
          state_d    = IDLE;
        end else if (rxd == PRE_BYTE) begin
          if (pre_q == 3'(MAX_PRE)) begin
            report     = 1'b1;
            rep_status = ERR_PRE;
            state_d    = DROP;
          end else begin
            pre_d = pre_q + 3'd1;
          end
        end else if (rxd == SFD_BYTE) begin
          state_d = DATA;
          sum_d   = '0;
          n_d     = '0;
          clear   = 1'b1;
        end else begin
          report     = 1'b1;
          rep_status = ERR_PRE;
          state_d    = DROP;
        end
      end
      DATA: begin
        if (!rx_dv) begin
          state_d = IDLE;
          flush   = 1'b1;
          report  = 1'b1;
          if (n_q < NW'(2))       rep_status = ERR_LEN;
          else if (sum_q == '0)   rep_status = OK;
          else                    rep_status = ERR_CSUM;
        end else if (n_q == N_OVF) begin
          // Overlength: drop the held bytes so no m_last is ever produced.
          clear      = 1'b1;
          report     = 1'b1;
          rep_status = ERR_LEN;
          state_d    = DROP;
        end else begin
          push  = 1'b1;
          sum_d = sum_q + rxd;
          n_d   = n_q + 1'b1;
        end
      end
      DROP: if (!rx_dv) state_d = IDLE;
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_IDLE;
      pre_q    <= '0;
      sum_q    <= '0;
      n_q      <= '0;
      done_q   <= 1'b0;
      status_q <= OK;
      ok_q     <= '0;
      err_q    <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      sum_q   <= sum_d;
      n_q     <= n_d;
      done_q  <= report;
      if (report) begin
        status_q <= rep_status;
        if (rep_status == OK) ok_q  <= ok_q + 1'b1;
        else                  err_q <= err_q + 1'b1;
      end
    end
  end

  frame_rx_hold u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .flush_i (flush),
    .clear_i (clear),
    .data_i  (rxd),
    .data_o  (m_data),
    .valid_o (m_valid),
    .last_o  (m_last)
  );

  assign frame_done   = done_q;
  assign frame_status = status_q;
  assign ok_cnt       = ok_q;
  assign err_cnt      = err_q;

endmodule

// File: tb/tb_frame_rx.sv
// Scoreboard bench for frame_rx: reference model classifies whole frames, monitor compares outputs.
module tb_frame_rx;

  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rxd = '0;
  logic             rx_dv = 1'b0;
  logic [7:0]       m_data;
  logic             m_valid, m_last, frame_done;
  logic [1:0]       frame_status;
  logic [CNT_W-1:0] ok_cnt, err_cnt;

  frame_rx #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rxd          (rxd),
    .rx_dv        (rx_dv),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .frame_done   (frame_done),
    .frame_status (frame_status),
    .ok_cnt       (ok_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {logic [7:0] data; logic last;} beat_t;
  typedef struct packed {logic [1:0] status; logic [CNT_W-1:0] ok; logic [CNT_W-1:0] err;} done_t;

  beat_t       exp_beats[$];
  done_t       exp_done[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned ok_m = 0;
  int unsigned err_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Classify a complete frame from its byte list and queue the expected response.
  task automatic model(input bq_t fr);
    int unsigned p = 0;
    int unsigned sum = 0;
    bq_t         body;
    logic [1:0]  st;
    beat_t       b;
    done_t       d;
    while (p < fr.size() && fr[p] == 8'h55) p++;
    if (p == 0 || p >= 8 || p == fr.size()) st = 2'd3;
    else if (fr[p] != 8'hD5) st = 2'd3;
    else begin
      for (int unsigned i = p + 1; i < fr.size(); i++) body.push_back(fr[i]);
      if (body.size() > MAX_LEN + 1) begin
        for (int unsigned i = 0; i < MAX_LEN - 1; i++) begin
          b.data = body[i]; b.last = 1'b0; exp_beats.push_back(b);
        end
        st = 2'd2;
      end else if (body.size() < 2) begin
        st = 2'd2;
      end else begin
        foreach (body[i]) sum += body[i];
        for (int unsigned i = 0; i + 1 < body.size(); i++) begin
          b.data = body[i]; b.last = (i + 2 == body.size()); exp_beats.push_back(b);
        end
        st = (sum % 256 == 0) ? 2'd0 : 2'd1;
      end
    end
    if (st == 2'd0) ok_m++; else err_m++;
    d.status = st; d.ok = CNT_W'(ok_m); d.err = CNT_W'(err_m);
    exp_done.push_back(d);
  endtask

  task automatic send(input bq_t fr, input int unsigned gap);
    model(fr);
    foreach (fr[i]) begin
      @(posedge clk); #1;
      rxd = fr[i]; rx_dv = 1'b1;
    end
    repeat (gap) begin
      @(posedge clk); #1;
      rx_dv = 1'b0; rxd = 8'($urandom);
    end
  endtask

  function automatic bq_t mk(input int unsigned npre, input bq_t body);
    bq_t f;
    repeat (npre) f.push_back(8'h55);
    f.push_back(8'hD5);
    foreach (body[i]) f.push_back(body[i]);
    return f;
  endfunction

  task automatic check_reset_outputs();
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_status", 32'(frame_status), 0);
    check("rst_ok_cnt", 32'(ok_cnt), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
  endtask

  always @(negedge clk) begin : monitor
    beat_t b;
    done_t d;
    if (rst_n) begin
      if (m_valid) begin
        if (exp_beats.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got data %0h last %0b expected none at %0t", m_data, m_last, $time);
        end else begin
          b = exp_beats.pop_front();
          check("m_data", 32'(m_data), 32'(b.data));
          check("m_last", 32'(m_last), 32'(b.last));
        end
      end else begin
        check("m_last_idle", 32'(m_last), 0);
      end
      if (frame_done) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got status %0d expected none at %0t", frame_status, $time);
        end else begin
          d = exp_done.pop_front();
          check("frame_status", 32'(frame_status), 32'(d.status));
          check("ok_cnt", 32'(ok_cnt), 32'(d.ok));
          check("err_cnt", 32'(err_cnt), 32'(d.err));
        end
      end
    end
  end

  initial begin
    bq_t fr, t;
    int unsigned kind, nb;
    int unsigned s;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed frames from the test plan.
    t = '{8'h01, 8'h02, 8'h03, 8'hFA};
    send(mk(7, t), 1);
    t = '{8'h01, 8'h02, 8'h03, 8'hFB};
    send(mk(7, t), 1);
    t = '{8'h01, 8'h02};
    fr = mk(8, t);
    send(fr, 2);
    t = '{8'hD5, 8'h01, 8'h02};
    send(t, 1);
    t = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hF1};
    send(mk(3, t), 1);
    t = '{8'h07};
    send(mk(1, t), 1);
    t = '{8'h01, 8'h02, 8'h03, 8'hFA};
    send(mk(7, t), 1);
    send(mk(7, t), 1);
    t = '{8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
    send(mk(2, t), 1);
    t = '{8'h55, 8'h55};
    send(t, 1);
    repeat (6) @(posedge clk);

    // Reset during payload byte 02, released while rx_dv is still high.
    t = '{8'h01, 8'h02, 8'h03, 8'hFA};
    fr = mk(7, t);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1; rxd = fr[i]; rx_dv = 1'b1;
    end
    @(posedge clk); #1; rxd = fr[9];
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1; rxd = fr[10]; rst_n = 1'b1;
    @(posedge clk); #1; rxd = fr[11];
    @(posedge clk); #1; rx_dv = 1'b0;
    repeat (4) @(posedge clk);
    ok_m = 0; err_m = 0;
    send(mk(7, t), 1);

    // Randomized frames covering good, checksum, length and preamble cases.
    for (int k = 0; k < 300; k++) begin
      fr.delete();
      kind = $urandom_range(0, 9);
      if (kind == 4) fr.push_back(8'($urandom_range(0, 255)));
      repeat ((kind == 0) ? $urandom_range(8, 9) : $urandom_range(1, 7)) fr.push_back(8'h55);
      if (kind == 1) fr.push_back(8'($urandom_range(0, 255)));
      else if (kind != 2) fr.push_back(8'hD5);
      nb = $urandom_range(0, 7);
      s = 0;
      for (int unsigned i = 1; i < nb; i++) begin
        fr.push_back(8'($urandom_range(0, 255)));
        s += fr[fr.size() - 1];
      end
      if (nb > 0) fr.push_back(8'((256 - (s % 256)) + ((kind == 3) ? $urandom_range(1, 255) : 0)));
      send(fr, $urandom_range(1, 3));
    end

    repeat (10) @(posedge clk);
    check("beats_left", 32'(exp_beats.size()), 0);
    check("dones_left", 32'(exp_done.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
